output_fifo: RTL and testbench
==============================

OUTPUT_FIFO -- requirements
Module: output_fifo

Interface
REQ-001 Parameter DEPTH, default 4, number of 8-bit entries; SHALL be a power of two, at least 2.
REQ-002 Parameter DATA_W, default 8, width of each entry; SHALL match the processor datapath width.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port wr_en  input  1  processor output-write strobe (controller OUTwe).
REQ-006 Port wr_data  input  DATA_W  value to enqueue (ALU result, low DATA_W bits).
REQ-007 Port full  output  1  high when count == DEPTH; the processor uses it to hold off OUT instructions.
REQ-008 Port m_valid  output  1  head entry available to the external sink.
REQ-009 Port m_data  output  DATA_W  head entry.
REQ-010 Port m_ready  input  1  the sink accepts the head entry when m_valid && m_ready.
REQ-011 Port out_port  output  DATA_W  last accepted write value (legacy mirror port).
REQ-012 Port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-013 Port ovf  output  1  sticky flag: a write was dropped.
REQ-014 Port ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-015 Storage SHALL be a circular buffer with read and write pointers carrying one extra wrap bit; full = pointers equal except for the wrap bit; empty = pointers fully equal.
REQ-016 Write acceptance SHALL be wr_en && !full, with full taken from the current registered state; an accepted write stores wr_data at the write pointer and increments the pointer modulo 2*DEPTH.
REQ-017 Read SHALL occur on m_valid && m_ready, incrementing the read pointer modulo 2*DEPTH.
REQ-018 m_valid SHALL equal !empty; there is no fall-through, so the first entry is visible exactly 1 cycle after its accepted write.
REQ-019 While m_valid && !m_ready, m_data and m_valid SHALL remain stable.
REQ-020 A read and write in the same cycle SHALL leave count unchanged and SHALL be legal at any non-empty, non-full occupancy.
REQ-021 When full, a simultaneous read and write SHALL complete the read, drop the write, and leave count = DEPTH-1.
REQ-022 When empty, a simultaneous read and write SHALL accept the write; the read is a no-op because m_valid is 0.
REQ-023 out_port SHALL load wr_data on every accepted write and hold otherwise; dropped writes SHALL NOT update it.
REQ-024 count SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH.

Reset
REQ-025 Asserting rst_n low SHALL immediately clear both pointers, count, out_port and ovf to 0, and force full=0 and m_valid=0, regardless of any transaction in flight.
REQ-026 Storage contents need not reset; m_data is don't-care while m_valid=0.
REQ-027 The first write SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro OUTPUT_FIFO_OVF_EN, when defined: a dropped write (wr_en && full) SHALL set ovf on the next edge; ovf_clr SHALL clear it; set SHALL win over a simultaneous clear.
REQ-029 When OUTPUT_FIFO_OVF_EN is undefined, ovf SHALL be tied to 0, ovf_clr SHALL be ignored, and no overflow logic SHALL be synthesized; ports SHALL be identical in both builds.

Structure
REQ-030 Shared package project_pkg SHALL hold DATA_W_DEF (8), OFIFO_DEPTH_DEF (4) and the pointer/count width function.
REQ-031 The storage array SHALL be a sub-module fifo_mem (one synchronous write port, one asynchronous read port, no reset); pointer, flag and mirror logic stay in output_fifo.

Verification
REQ-032 Reset, then write 0x5A with m_ready=0 -> m_valid=1 on the next cycle, m_data=0x5A, out_port=0x5A, count=1.
REQ-033 Four writes 0x01-0x04 with m_ready=0 -> full=1, count=4; a fifth write of 0x05 is dropped, out_port stays 0x04, ovf=1 (macro built) or ovf=0 (macro not built).
REQ-034 Full FIFO, then m_ready=1 plus a write of 0x09 in the same cycle -> 0x01 is read, 0x09 is dropped, count=3; draining then yields 0x02, 0x03, 0x04.
REQ-035 Ten write/read cycles with m_ready=1 -> pointers wrap, count never exceeds 1, and the data is delivered in order.
REQ-036 Three entries stored, rst_n pulsed low mid-cycle -> m_valid, full, count and out_port drop to 0 without waiting for a clock edge; a post-reset write of 0xA5 is delivered alone.
REQ-037 ovf=1 with ovf_clr=1 and a dropped write in the same cycle -> ovf stays 1; on the next cycle, ovf_clr alone -> ovf=0.

Source files
------------

// File: rtl/project_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : project_pkg
//  Description : Shared defaults and helpers for the processor output path.
//                DATA_W_DEF      - processor datapath width
//                OFIFO_DEPTH_DEF - default output FIFO depth (entries)
//                ptr_w()         - pointer/count width for a given depth:
//                                  address bits plus one wrap bit
//  Revision    : 1.0 - initial release
// ============================================================================
package project_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int OFIFO_DEPTH_DEF = 4;

  // Pointers carry one bit beyond the address so full and empty can be told
  // apart; the occupancy count needs the same width to represent DEPTH.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : project_pkg
`default_nettype wire

// File: rtl/output_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : output_fifo_if
//  Description : Bus bundle between the processor/sink side and output_fifo.
//                Write side : wr_en, wr_data -> full, out_port
//                Sink side  : m_ready        -> m_valid, m_data
//                Status     : ovf_clr        -> ovf, count
//                modport master : processor + sink (drives wr_*, m_ready,
//                                 ovf_clr)
//                modport slave  : the FIFO itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface output_fifo_if
  import project_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = OFIFO_DEPTH_DEF
);

  logic                    wr_en;
  logic [DATA_W-1:0]       wr_data;
  logic                    full;
  logic                    m_valid;
  logic [DATA_W-1:0]       m_data;
  logic                    m_ready;
  logic [DATA_W-1:0]       out_port;
  logic [ptr_w(DEPTH)-1:0] count;
  logic                    ovf;
  logic                    ovf_clr;

  modport master (
    output wr_en, wr_data, m_ready, ovf_clr,
    input  full, m_valid, m_data, out_port, count, ovf
  );

  modport slave (
    input  wr_en, wr_data, m_ready, ovf_clr,
    output full, m_valid, m_data, out_port, count, ovf
  );

endinterface : output_fifo_if
`default_nettype wire

// File: rtl/fifo_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Storage array for output_fifo. One synchronous write port,
//                one asynchronous read port, no reset (contents are only
//                observed once written).
//                clk   - write clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  wire logic                       clk,
  input  wire logic                       we,
  input  wire logic [$clog2(DEPTH)-1:0]   waddr,
  input  wire logic [DATA_W-1:0]          wdata,
  input  wire logic [$clog2(DEPTH)-1:0]   raddr,
  output logic      [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/output_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : output_fifo
//  Description : Processor output FIFO. Buffers OUT-instruction results for
//                an external valid/ready sink and mirrors the last accepted
//                value on out_port.
//                clk   - clock, all state on rising edge
//                rst_n - asynchronous active-low reset
//                bus   - output_fifo_if.slave (wr_en/wr_data/full,
//                        m_valid/m_data/m_ready, out_port, count, ovf/ovf_clr)
//  Options     : OUTPUT_FIFO_OVF_EN - when defined, builds the sticky
//                overflow flag; otherwise ovf is tied low and ovf_clr is
//                ignored. Ports are the same in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_fifo
  import project_pkg::*;
#(
  parameter int DEPTH  = OFIFO_DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  output_fifo_if.slave  bus
);

  localparam int                 c_addr_w  = $clog2(DEPTH);
  localparam int                 c_ptr_w   = ptr_w(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  out_port_q, out_port_d;

  logic w_empty;
  logic w_full;
  logic w_wr_accept;
  logic w_rd_accept;

  // Same address with opposite wrap bits means the writer is a full lap ahead.
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[c_ptr_w-1] != rd_ptr_q[c_ptr_w-1]) &&
                   (wr_ptr_q[c_addr_w-1:0] == rd_ptr_q[c_addr_w-1:0]);

  // Both decisions use registered flags only: a read in the same cycle does
  // not free space for a write, and a write does not make an empty FIFO
  // readable until the following cycle.
  assign w_wr_accept = bus.wr_en && !w_full;
  assign w_rd_accept = !w_empty && bus.m_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    out_port_d = out_port_q;
    if (w_wr_accept) begin
      wr_ptr_d   = wr_ptr_q + c_ptr_one;
      out_port_d = bus.wr_data;
    end
    if (w_rd_accept) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_port_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_port_q <= out_port_d;
    end
  end

  fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_accept),
    .waddr (wr_ptr_q[c_addr_w-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_q[c_addr_w-1:0]),
    .rdata (bus.m_data)
  );

  // Flags are decoded from the pointers, so they follow an asynchronous
  // reset immediately.
  assign bus.full     = w_full;
  assign bus.m_valid  = !w_empty;
  assign bus.count    = wr_ptr_q - rd_ptr_q;
  assign bus.out_port = out_port_q;

`ifdef OUTPUT_FIFO_OVF_EN
  logic ovf_q, ovf_d;

  // A dropped write in the same cycle as a clear wins, so no overflow event
  // is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (bus.wr_en && w_full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic w_unused_ovf_clr;

  assign w_unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf          = 1'b0;
`endif

endmodule : output_fifo
`default_nettype wire

// File: tb/tb_output_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_output_fifo
//  Description : Self-checking bench for output_fifo (default DEPTH=4,
//                DATA_W=8). Directed table, multi-cycle corner sequences and
//                a randomized run against a queue-based reference model.
//                Honours OUTPUT_FIFO_OVF_EN for the expected ovf value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_fifo;
  import project_pkg::*;

  localparam int DEPTH  = OFIFO_DEPTH_DEF;
  localparam int DATA_W = DATA_W_DEF;

`ifdef OUTPUT_FIFO_OVF_EN
  localparam bit OVF_BUILT = 1'b1;
`else
  localparam bit OVF_BUILT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  output_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  output_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO is just an ordered queue of bytes.
  logic [DATA_W-1:0] mdl_q[$];
  logic [DATA_W-1:0] mdl_out;
  logic              mdl_ovf;

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       m_ready;
    logic       ovf_clr;
    int         exp_count;
    logic       exp_full;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [7:0] exp_out;
    logic       exp_ovf;   // value when the overflow option is built
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.m_ready = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_valid", 32'(bus.m_valid), 0);
    chk("rst_out_port", 32'(bus.out_port), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst_n = 1'b1;
    mdl_q.delete();
    mdl_out = '0;
    mdl_ovf = 1'b0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit was_full;
    bit do_rd;
    bit do_wr;
    was_full = (mdl_q.size() == DEPTH);
    do_rd    = (mdl_q.size() != 0) && bus.m_ready;
    do_wr    = bus.wr_en && !was_full;
    if (do_rd) void'(mdl_q.pop_front());
    if (do_wr) begin
      mdl_q.push_back(bus.wr_data);
      mdl_out = bus.wr_data;
    end
    if (OVF_BUILT) begin
      if (bus.ovf_clr) mdl_ovf = 1'b0;
      if (bus.wr_en && was_full) mdl_ovf = 1'b1;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'(mdl_q.size()));
    chk({tag, "_full"}, 32'(bus.full), 32'(mdl_q.size() == DEPTH));
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) chk({tag, "_data"}, 32'(bus.m_data), 32'(mdl_q[0]));
    chk({tag, "_out_port"}, 32'(bus.out_port), 32'(mdl_out));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(mdl_ovf));
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd, input logic rdy,
                              input logic clr, input int cnt, input logic f,
                              input logic v, input logic [7:0] d, input logic [7:0] o,
                              input logic ov);
    vec_t t;
    t.wr_en = we; t.wr_data = wd; t.m_ready = rdy; t.ovf_clr = clr;
    t.exp_count = cnt; t.exp_full = f; t.exp_valid = v; t.exp_data = d;
    t.exp_out = o; t.exp_ovf = ov;
    return t;
  endfunction

  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // ---------------- directed table ----------------
    //            we  data   rdy clr cnt full val data  out  ovf
    vecs.push_back(mk(1, 8'h5A, 0, 0, 1, 0, 1, 8'h5A, 8'h5A, 0)); // first write after reset
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h5A, 0)); // drain it
    vecs.push_back(mk(1, 8'h01, 0, 0, 1, 0, 1, 8'h01, 8'h01, 0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 2, 0, 1, 8'h01, 8'h02, 0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 3, 0, 1, 8'h01, 8'h03, 0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 4, 1, 1, 8'h01, 8'h04, 0)); // now full
    vecs.push_back(mk(1, 8'h05, 0, 0, 4, 1, 1, 8'h01, 8'h04, 1)); // dropped
    vecs.push_back(mk(1, 8'h06, 0, 1, 4, 1, 1, 8'h01, 8'h04, 1)); // set beats clear
    vecs.push_back(mk(0, 8'h00, 0, 1, 4, 1, 1, 8'h01, 8'h04, 0)); // clear alone
    vecs.push_back(mk(1, 8'h09, 1, 0, 3, 0, 1, 8'h02, 8'h04, 1)); // read 01, drop 09
    vecs.push_back(mk(0, 8'h00, 1, 0, 2, 0, 1, 8'h03, 8'h04, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 8'h04, 8'h04, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 8'h04, 1)); // empty
    vecs.push_back(mk(1, 8'h77, 1, 1, 1, 0, 1, 8'h77, 8'h77, 0)); // empty: read no-op

    #3;
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      bus.wr_en   = vecs[i].wr_en;
      bus.wr_data = vecs[i].wr_data;
      bus.m_ready = vecs[i].m_ready;
      bus.ovf_clr = vecs[i].ovf_clr;
      tick();
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      chk($sformatf("v%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
      chk($sformatf("v%0d_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("v%0d_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_out_port", i), 32'(bus.out_port), 32'(vecs[i].exp_out));
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf & OVF_BUILT));
    end

    // ---------------- streaming: write and read every cycle ----------------
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
      tick();
      chk($sformatf("stream%0d_count", i), 32'(bus.count), 1);
      chk($sformatf("stream%0d_data", i), 32'(bus.m_data), 32'(8'h10 + i));
    end
    bus.wr_en = 1'b0;
    tick();
    chk("stream_end_count", 32'(bus.count), 0);
    chk("stream_end_valid", 32'(bus.m_valid), 0);

    // ---------------- asynchronous reset mid-cycle ----------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'(8'h30 + i);
      tick();
    end
    chk("pre_arst_count", 32'(bus.count), 3);
    #2 rst_n = 1'b0;        // write still requested: in-flight transaction
    #1;
    chk("arst_valid", 32'(bus.m_valid), 0);
    chk("arst_full", 32'(bus.full), 0);
    chk("arst_count", 32'(bus.count), 0);
    chk("arst_out_port", 32'(bus.out_port), 0);
    chk("arst_ovf", 32'(bus.ovf), 0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hA5;
    tick();
    bus.wr_en   = 1'b0;
    chk("post_arst_count", 32'(bus.count), 1);
    chk("post_arst_data", 32'(bus.m_data), 32'hA5);
    chk("post_arst_out_port", 32'(bus.out_port), 32'hA5);
    bus.m_ready = 1'b1;
    tick();
    chk("post_arst_drained", 32'(bus.m_valid), 0);

    // ---------------- randomized run against the model ----------------
    do_reset();
    for (int i = 0; i < 800; i++) begin
      int pw;
      int pr;
      pw = (i < 400) ? 70 : 35;
      pr = (i < 400) ? 35 : 70;
      bus.wr_en   = ($urandom_range(99, 0) < pw);
      bus.wr_data = 8'($urandom);
      bus.m_ready = ($urandom_range(99, 0) < pr);
      bus.ovf_clr = ($urandom_range(99, 0) < 10);
      model_step();
      tick();
      compare_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_output_fifo
`default_nettype wire
